// File: rtl/conv3x3_window_gen.sv
// conv3x3_window_gen
// Pops a raster-scan pixel stream from the conv3x3 input FIFO (1-cycle read
// latency). It keeps two previous rows in line buffers and emits every fully
// populated 3x3 window, with no padding, to the MAC array.
// Optional feature: define WINGEN_PERF_CNT_EN to add the stall_cnt output.
//
// Handshake: there is no valid/ready pair on the window side. The window
// output is a pure valid stream: win_valid marks a window on win_data, and the
// consumer must take it in that same cycle. On the FIFO side a pop is
// accepted in any cycle with fifo_rd_en=1. fifo_rd_en is never raised while
// fifo_empty=1. The popped word appears on fifo_rd_data in the next cycle.
module conv3x3_window_gen #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
    input  logic                    fifo_empty,
    output logic                    fifo_rd_en,
    output logic [9*DATA_WIDTH-1:0] win_data,
    output logic                    win_valid,
    output logic [9:0]              win_row,
    output logic [9:0]              win_col,
    output logic                    busy,
    output logic                    done,
`ifdef WINGEN_PERF_CNT_EN
    output logic [31:0]             stall_cnt,
`endif
    output logic [1:0]              state_dbg
);

    localparam int DW    = DATA_WIDTH;
    localparam int TOTAL = IMG_W * IMG_H;
    localparam int AW    = $clog2(IMG_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [20:0]     pop_cnt;
    logic            cap_vld;   // fifo_rd_data holds a pixel this cycle
    logic [9:0]      col, row;  // position of the pixel being captured
    logic [AW-1:0]   col_idx;
    logic [DW-1:0]   lb0 [IMG_W];  // previous row
    logic [DW-1:0]   lb1 [IMG_W];  // row before that
    logic [9*DW-1:0] win_shift;
    logic            start_ok;

    assign start_ok   = (state == IDLE) && start;
    assign col_idx    = col[AW-1:0];
    assign fifo_rd_en = (state == RUN) && !fifo_empty && (pop_cnt < 21'(TOTAL));
    assign busy       = (state == RUN) || (state == FLUSH);
    assign done       = (state == DONE);
    assign state_dbg  = state;

    // State register plus pop/capture bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pop_cnt <= '0;
            cap_vld <= 1'b0;
            col     <= '0;
            row     <= '0;
        end else begin
            state   <= state_nxt;
            cap_vld <= fifo_rd_en;
            if (start_ok) begin
                pop_cnt <= '0;
                col     <= '0;
                row     <= '0;
            end else begin
                if (fifo_rd_en) pop_cnt <= pop_cnt + 21'd1;
                if (cap_vld) begin
                    if (col == 10'(IMG_W - 1)) begin
                        col <= '0;
                        if (row != 10'(IMG_H - 1)) row <= row + 10'd1;
                    end else begin
                        col <= col + 10'd1;
                    end
                end
            end
        end
    end

    // Next-state logic; FLUSH ends once the final captured pixel has left the window.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (fifo_rd_en && (pop_cnt == 21'(TOTAL - 1))) state_nxt = FLUSH;
            FLUSH:   if (!cap_vld) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shift the window left by one column and append {linebuf1, linebuf0, new pixel}.
    always_comb begin
        win_shift = win_data;
        for (int r = 0; r < 3; r++) begin
            win_shift[DW*(3*r)   +: DW] = win_data[DW*(3*r+1) +: DW];
            win_shift[DW*(3*r+1) +: DW] = win_data[DW*(3*r+2) +: DW];
        end
        win_shift[DW*2 +: DW] = lb1[col_idx];
        win_shift[DW*5 +: DW] = lb0[col_idx];
        win_shift[DW*8 +: DW] = fifo_rd_data;
    end

    // Line buffers carry no reset; every entry is rewritten before it is used in a valid window.
    always_ff @(posedge clk) begin
        if (cap_vld) begin
            lb1[col_idx] <= lb0[col_idx];
            lb0[col_idx] <= fifo_rd_data;
        end
    end

    // Window output registers; these hold their value through FIFO bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_data  <= '0;
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
        end else begin
            win_valid <= cap_vld && (row >= 10'd2) && (col >= 10'd2);
            if (cap_vld) begin
                win_data <= win_shift;
                win_row  <= row;
                win_col  <= col;
            end
        end
    end

`ifdef WINGEN_PERF_CNT_EN
    // Count cycles spent waiting on an empty FIFO while in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             stall_cnt <= '0;
        else if (start_ok)                      stall_cnt <= '0;
        else if ((state == RUN) && fifo_empty)  stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_conv3x3_window_gen.sv
// Bench for conv3x3_window_gen: an 8x8 instance fed by a queue-based FIFO model,
// plus a 3x3 instance for the minimum image size.
module tb_conv3x3_window_gen;

    localparam int DW = 16;
    localparam int W  = 8;
    localparam int H  = 8;

    // ---------------- clock / reset ----------------
    logic clk_tb = 1'b0;
    logic tb_rst = 1'b0;
    always #5 clk_tb = ~clk_tb;

    // ---------------- 8x8 DUT ----------------
    logic            start = 1'b0;
    logic [DW-1:0]   fifo_rd_data = '0;
    logic            fifo_empty = 1'b1;
    logic            fifo_rd_en;
    logic [9*DW-1:0] win_data;
    logic            win_valid;
    logic [9:0]      win_row, win_col;
    logic            busy, done;
    logic [1:0]      state_dbg;
`ifdef WINGEN_PERF_CNT_EN
    logic [31:0]     stall_cnt;
`endif

    conv3x3_window_gen #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk_tb), .rst_n(tb_rst), .start(start),
        .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .win_data(win_data), .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
        .busy(busy), .done(done),
`ifdef WINGEN_PERF_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .state_dbg(state_dbg)
    );

    // ---------------- 3x3 DUT ----------------
    logic            b_start = 1'b0;
    logic [DW-1:0]   b_rd_data = '0;
    logic            b_empty = 1'b1;
    logic            b_rd_en;
    logic [9*DW-1:0] b_win_data;
    logic            b_win_valid;
    logic [9:0]      b_win_row, b_win_col;
    logic            b_busy, b_done;
    logic [1:0]      b_state_dbg;
`ifdef WINGEN_PERF_CNT_EN
    logic [31:0]     b_stall_cnt;
`endif

    conv3x3_window_gen #(.DATA_WIDTH(DW), .IMG_W(3), .IMG_H(3)) dut_b (
        .clk(clk_tb), .rst_n(tb_rst), .start(b_start),
        .fifo_rd_data(b_rd_data), .fifo_empty(b_empty), .fifo_rd_en(b_rd_en),
        .win_data(b_win_data), .win_valid(b_win_valid), .win_row(b_win_row), .win_col(b_win_col),
        .busy(b_busy), .done(b_done),
`ifdef WINGEN_PERF_CNT_EN
        .stall_cnt(b_stall_cnt),
`endif
        .state_dbg(b_state_dbg)
    );

    // ---------------- scoreboard state ----------------
    logic [DW-1:0]  q[$];       // FIFO model contents
    logic [DW-1:0]  qb[$];
    logic [163:0]   exp_q[$];   // {row, col, window}
    int             passed = 0;
    int             total  = 0;
    int             win_cnt, done_cnt, pop_total;
    logic           prev_valid = 1'b0;
    logic           rd_now = 1'b0;
    logic           force_empty = 1'b0;
    logic           toggle_mode = 1'b0;
    logic [9*DW-1:0] first_win, last_win;

    task automatic chk(input string tag, input logic [163:0] obs, input logic [163:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [9*DW-1:0] pack9(input int p0, p1, p2, p3, p4, p5, p6, p7, p8);
        logic [9*DW-1:0] r;
        r = '0;
        r[DW*0 +: DW] = DW'(p0); r[DW*1 +: DW] = DW'(p1); r[DW*2 +: DW] = DW'(p2);
        r[DW*3 +: DW] = DW'(p3); r[DW*4 +: DW] = DW'(p4); r[DW*5 +: DW] = DW'(p5);
        r[DW*6 +: DW] = DW'(p6); r[DW*7 +: DW] = DW'(p7); r[DW*8 +: DW] = DW'(p8);
        return r;
    endfunction

    // Pixel (r,c) of a frame is base + r*W + c.
    task automatic expect_frame(input int base);
        logic [9*DW-1:0] w;
        for (int rr = 2; rr < H; rr++)
            for (int cc = 2; cc < W; cc++) begin
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        w[DW*(3*r+c) +: DW] = DW'(base + (rr-2+r)*W + (cc-2+c));
                exp_q.push_back({10'(rr), 10'(cc), w});
            end
    endtask

    task automatic push_pixels(input int base, input int from, input int n);
        for (int i = from; i < from + n; i++) q.push_back(DW'(base + i));
    endtask

    task automatic new_frame_counters();
        win_cnt = 0; done_cnt = 0; pop_total = 0; prev_valid = 1'b0;
    endtask

    // One clock cycle: drive empty at negedge, check outputs, model FIFO pop after posedge.
    task automatic tick();
        logic [163:0] e;
        @(negedge clk_tb);
        if (toggle_mode) force_empty = ~force_empty;
        fifo_empty = (q.size() == 0) || force_empty;
        #1;
        rd_now = fifo_rd_en;
        chk("pop_while_empty", {163'd0, rd_now && fifo_empty}, 164'd0);
        if (win_valid) begin
            win_cnt++;
            if (win_cnt == 1) first_win = win_data;
            last_win = win_data;
            chk("win_col_ge2", {163'd0, win_col >= 10'd2}, 164'd1);
            if (exp_q.size() == 0) chk("extra_window", 164'd1, 164'd0);
            else begin
                e = exp_q.pop_front();
                chk("win_data", {20'd0, win_data}, {20'd0, e[143:0]});
                chk("win_pos", {144'd0, win_row, win_col}, {144'd0, e[163:144]});
            end
        end
        if (done) begin
            done_cnt++;
            chk("done_after_last", {163'd0, prev_valid}, 164'd1);
            chk("done_all_windows", 164'(exp_q.size()), 164'd0);
        end
        prev_valid = win_valid;
        @(posedge clk_tb);
        #1;
        start = 1'b0;
        if (rd_now) begin
            fifo_rd_data = q.pop_front();
            pop_total++;
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt == 0) chk("done_timeout", 164'd0, 164'd1);
        tick();
        tick();
    endtask

    task automatic check_frame_end(input string tag);
        chk({tag, "_win_count"}, 164'(win_cnt), 164'd36);
        chk({tag, "_done_count"}, 164'(done_cnt), 164'd1);
        chk({tag, "_idle"}, {162'd0, busy, done}, 164'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, {163'd0, fifo_rd_en}, 164'd0);
        chk({tag, "_win_valid"}, {163'd0, win_valid}, 164'd0);
        chk({tag, "_win_data"}, {20'd0, win_data}, 164'd0);
        chk({tag, "_win_rc"}, {144'd0, win_row, win_col}, 164'd0);
        chk({tag, "_busy_done"}, {162'd0, busy, done}, 164'd0);
        chk({tag, "_state"}, {162'd0, state_dbg}, 164'd0);
    endtask

    initial begin
        int b_wins;
        logic b_done_seen;
        logic b_rd_now;

        // ---- reset ----
        repeat (3) @(posedge clk_tb);
        @(negedge clk_tb);
        check_reset_outputs("reset");
        tb_rst = 1'b1;
        @(posedge clk_tb); #1;

        // ---- 1: full preloaded frame 1..64 ----
        new_frame_counters();
        push_pixels(1, 0, 64);
        expect_frame(1);
        start = 1'b1;
        wait_done(300);
        check_frame_end("f1");
        chk("f1_first", {20'd0, first_win}, {20'd0, pack9(1, 2, 3, 9, 10, 11, 17, 18, 19)});
        chk("f1_last", {20'd0, last_win}, {20'd0, pack9(46, 47, 48, 54, 55, 56, 62, 63, 64)});
        chk("f1_hold", {20'd0, win_data}, {20'd0, pack9(46, 47, 48, 54, 55, 56, 62, 63, 64)});

        // ---- 2: 20 pixels, 30-cycle gap, then the rest ----
        new_frame_counters();
        push_pixels(1, 0, 20);
        expect_frame(1);
        start = 1'b1;
        for (int i = 0; i < 100 && pop_total < 20; i++) tick();
        chk("f2_first_pops", 164'(pop_total), 164'd20);
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("f2_gap_rd_en", {163'd0, rd_now}, 164'd0);
        end
        chk("f2_gap_busy", {163'd0, busy}, 164'd1);
        push_pixels(1, 20, 44);
        wait_done(300);
        check_frame_end("f2");
`ifdef WINGEN_PERF_CNT_EN
        chk("f2_stall_cnt", {132'd0, stall_cnt}, 164'd30);
`endif

        // ---- 3: empty toggles every other cycle ----
        new_frame_counters();
        push_pixels(1, 0, 64);
        expect_frame(1);
        toggle_mode = 1'b1;
        start = 1'b1;
        wait_done(400);
        toggle_mode = 1'b0;
        force_empty = 1'b0;
        check_frame_end("f3");

        // ---- 4: reset at pixel 30, then new frame 101..164 ----
        new_frame_counters();
        push_pixels(1, 0, 64);
        expect_frame(1);
        start = 1'b1;
        for (int i = 0; i < 100 && pop_total < 30; i++) tick();
        chk("f4_pops_before_rst", 164'(pop_total), 164'd30);
        @(negedge clk_tb);
        tb_rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        q.delete();
        exp_q.delete();
        fifo_empty = 1'b1;
        repeat (2) @(posedge clk_tb);
        @(negedge clk_tb);
        check_reset_outputs("midrst_hold");
        tb_rst = 1'b1;
        @(posedge clk_tb); #1;
        new_frame_counters();
        push_pixels(101, 0, 64);
        expect_frame(101);
        start = 1'b1;
        wait_done(300);
        check_frame_end("f4");
        chk("f4_first", {20'd0, first_win}, {20'd0, pack9(101, 102, 103, 109, 110, 111, 117, 118, 119)});

        // ---- 5: start pulsed again mid-frame ----
        new_frame_counters();
        push_pixels(1, 0, 64);
        expect_frame(1);
        start = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        start = 1'b1;
        tick();
        wait_done(300);
        check_frame_end("f5");

        // ---- 6: 3x3 image, pixels 1..9 ----
        for (int i = 1; i <= 9; i++) qb.push_back(DW'(i));
        b_wins = 0;
        b_done_seen = 1'b0;
        b_start = 1'b1;
        for (int cyc = 0; cyc < 40 && !b_done_seen; cyc++) begin
            @(negedge clk_tb);
            b_empty = (qb.size() == 0);
            #1;
            if (b_win_valid) begin
                b_wins++;
                chk("b_win_data", {20'd0, b_win_data}, {20'd0, pack9(1, 2, 3, 4, 5, 6, 7, 8, 9)});
                chk("b_win_pos", {144'd0, b_win_row, b_win_col}, {144'd0, 10'd2, 10'd2});
            end
            if (b_done) b_done_seen = 1'b1;
            b_rd_now = b_rd_en;
            @(posedge clk_tb); #1;
            b_start = 1'b0;
            if (b_rd_now) b_rd_data = qb.pop_front();
        end
        chk("b_win_count", 164'(b_wins), 164'd1);
        chk("b_done_seen", {163'd0, b_done_seen}, 164'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
